// File: rtl/regfile_pkg.sv
// Shared widths and the write-entry layout for the register-file writeback path.
package regfile_pkg;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int NREGS = 7;

    localparam logic [AW-1:0] REG_NONE = '0;

    typedef struct packed {
        logic [AW-1:0] sel;
        logic [DW-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular write buffer; entries are exposed oldest-first (index 0 = head).
// REGFILE_WB_FWD_EN adds per-entry data visibility for forwarding lookups.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = regfile_pkg::DW,
    parameter int AW    = regfile_pkg::AW,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [AW-1:0]       push_sel_i,
    input  logic [DW-1:0]       push_data_i,
    input  logic                pop_i,
    output logic [AW-1:0]       head_sel_o,
    output logic [DW-1:0]       head_data_o,
    output logic [CW-1:0]       count_o,
    output logic [DEPTH-1:0]    ent_vld_o,
`ifdef REGFILE_WB_FWD_EN
    output logic [DEPTH*DW-1:0] ent_data_o,
`endif
    output logic [DEPTH*AW-1:0] ent_sel_o
);

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    idx;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: validity comes solely from the count.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= {push_sel_i, push_data_i};
        end
    end

    assign head_sel_o  = mem_q[rd_ptr_q][DW +: AW];
    assign head_data_o = mem_q[rd_ptr_q][DW-1:0];
    assign count_o     = count_q;

    always_comb begin
        idx        = '0;
        ent_vld_o  = '0;
        ent_sel_o  = '0;
`ifdef REGFILE_WB_FWD_EN
        ent_data_o = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx                   = rd_ptr_q + PW'(i);
            ent_vld_o[i]          = (CW'(i) < count_q);
            ent_sel_o[i*AW +: AW] = mem_q[idx][DW +: AW];
`ifdef REGFILE_WB_FWD_EN
            ent_data_o[i*DW +: DW] = mem_q[idx][DW-1:0];
`endif
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: handshake, bypass, registered DSEL/RIN and busy scoreboard.
// Optional forwarding lookup enabled by REGFILE_WB_FWD_EN.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = regfile_pkg::DW,
    parameter int AW    = regfile_pkg::AW,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int NR   = (1 << AW) - 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RES_VALID,
    output logic          RES_READY,
    input  logic [AW-1:0] RES_DSEL,
    input  logic [DW-1:0] RES_DATA,
    output logic [AW-1:0] DSEL,
    output logic [DW-1:0] RIN,
    output logic [NR-1:0] BUSY,
`ifdef REGFILE_WB_FWD_EN
    input  logic [AW-1:0] FWD_SEL,
    output logic          FWD_HIT,
    output logic [DW-1:0] FWD_DATA,
`endif
    output logic [CW-1:0] QLEVEL
);

    logic [CW-1:0]       count;
    logic                fifo_empty;
    logic                fifo_full;
    logic                xfer;
    logic                wr_xfer;
    logic                push;
    logic                pop;
    logic [AW-1:0]       head_sel;
    logic [DW-1:0]       head_data;
    logic [DEPTH-1:0]    ent_vld;
    logic [DEPTH*AW-1:0] ent_sel;
`ifdef REGFILE_WB_FWD_EN
    logic [DEPTH*DW-1:0] ent_data;
`endif
    logic [AW-1:0]       dsel_q, dsel_d;
    logic [DW-1:0]       rin_q, rin_d;
    logic [NR-1:0]       busy;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));

    // Ready depends only on state; held low while reset is asserted.
    assign RES_READY = RST & ~fifo_full;
    assign xfer      = RES_VALID & RES_READY;
    assign wr_xfer   = xfer & (RES_DSEL != AW'(REG_NONE));

    // A queued head always wins; an incoming write only bypasses an empty queue.
    assign pop  = ~fifo_empty;
    assign push = wr_xfer & ~fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .push_i      (push),
        .push_sel_i  (RES_DSEL),
        .push_data_i (RES_DATA),
        .pop_i       (pop),
        .head_sel_o  (head_sel),
        .head_data_o (head_data),
        .count_o     (count),
        .ent_vld_o   (ent_vld),
`ifdef REGFILE_WB_FWD_EN
        .ent_data_o  (ent_data),
`endif
        .ent_sel_o   (ent_sel)
    );

    always_comb begin
        dsel_d = AW'(REG_NONE);
        rin_d  = rin_q;
        if (pop) begin
            dsel_d = head_sel;
            rin_d  = head_data;
        end else if (wr_xfer) begin
            dsel_d = RES_DSEL;
            rin_d  = RES_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dsel_q <= '0;
            rin_q  <= '0;
        end else begin
            dsel_q <= dsel_d;
            rin_q  <= rin_d;
        end
    end

    assign DSEL   = dsel_q;
    assign RIN    = rin_q;
    assign QLEVEL = count;

    always_comb begin
        busy = '0;
        for (int r = 1; r <= NR; r++) begin
            if (dsel_q == AW'(r)) begin
                busy[r-1] = 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld[i] && (ent_sel[i*AW +: AW] == AW'(r))) begin
                    busy[r-1] = 1'b1;
                end
            end
        end
    end

    assign BUSY = busy;

`ifdef REGFILE_WB_FWD_EN
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    // Output register is oldest; scanning head->tail lets the youngest match win.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (FWD_SEL != AW'(REG_NONE)) begin
            if (dsel_q == FWD_SEL) begin
                fwd_hit  = 1'b1;
                fwd_data = rin_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld[i] && (ent_sel[i*AW +: AW] == FWD_SEL)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = ent_data[i*DW +: DW];
                end
            end
        end
    end

    assign FWD_HIT  = fwd_hit;
    assign FWD_DATA = fwd_data;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: driver pushes accepted writes, monitor retires them.
module tb_regfile_wb_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int AW    = 3;

    typedef struct packed {
        logic [AW-1:0] sel;
        logic [DW-1:0] data;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RES_VALID = 1'b0;
    logic          RES_READY;
    logic [AW-1:0] RES_DSEL = '0;
    logic [DW-1:0] RES_DATA = '0;
    logic [AW-1:0] DSEL;
    logic [DW-1:0] RIN;
    logic [6:0]    BUSY;
    logic [2:0]    QLEVEL;
`ifdef REGFILE_WB_FWD_EN
    logic [AW-1:0] fwd_sel = '0;
    logic          FWD_HIT;
    logic [DW-1:0] FWD_DATA;
`endif

    wr_t           exp_q[$];
    wr_t           pend;
    bit            pend_vld = 1'b0;
    logic [DW-1:0] last_rin = '0;
    int            checks = 0;
    int            errors = 0;

    regfile_wb_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES_DSEL  (RES_DSEL),
        .RES_DATA  (RES_DATA),
        .DSEL      (DSEL),
        .RIN       (RIN),
        .BUSY      (BUSY),
`ifdef REGFILE_WB_FWD_EN
        .FWD_SEL   (fwd_sel),
        .FWD_HIT   (FWD_HIT),
        .FWD_DATA  (FWD_DATA),
`endif
        .QLEVEL    (QLEVEL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Commit the transfer decided before this edge, then present the next input.
    task automatic step(input logic v, input logic [AW-1:0] s, input logic [DW-1:0] d);
        @(posedge CLK);
        if (pend_vld) exp_q.push_back(pend);
        #2;
        RES_VALID = v;
        RES_DSEL  = s;
        RES_DATA  = d;
`ifdef REGFILE_WB_FWD_EN
        fwd_sel   = AW'($urandom_range(0, 7));
`endif
        pend_vld  = v && RES_READY && (s != '0);
        pend      = '{sel: s, data: d};
    endtask

    task automatic do_reset();
        @(posedge CLK);
        if (pend_vld) exp_q.push_back(pend);
        #2;
        RST       = 1'b0;
        RES_VALID = 1'b0;
        #1;
        check("rst_dsel",   32'(DSEL),      32'd0);
        check("rst_rin",    32'(RIN),       32'd0);
        check("rst_busy",   32'(BUSY),      32'd0);
        check("rst_qlevel", 32'(QLEVEL),    32'd0);
        check("rst_ready",  32'(RES_READY), 32'd0);
        exp_q.delete();
        pend_vld = 1'b0;
        last_rin = '0;
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
    endtask

    // Monitor: every edge retires the oldest accepted write, if any.
    always @(negedge CLK) begin : monitor
        wr_t        cur;
        logic [6:0] eb;
        logic       ehit;
        logic [DW-1:0] edata;
        if (RST) begin
            cur = '0;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check("dsel", 32'(DSEL), 32'(cur.sel));
                check("rin",  32'(RIN),  32'(cur.data));
                last_rin = cur.data;
            end else begin
                check("idle_dsel", 32'(DSEL), 32'd0);
                check("rin_hold",  32'(RIN),  32'(last_rin));
            end
            eb = '0;
            if (cur.sel != '0) eb[cur.sel - 1] = 1'b1;
            foreach (exp_q[k]) eb[exp_q[k].sel - 1] = 1'b1;
            check("busy",   32'(BUSY),      32'(eb));
            check("qlevel", 32'(QLEVEL),    32'(exp_q.size()));
            check("ready",  32'(RES_READY), 32'(exp_q.size() < DEPTH));
`ifdef REGFILE_WB_FWD_EN
            ehit  = 1'b0;
            edata = '0;
            if (fwd_sel != '0) begin
                if (cur.sel == fwd_sel) begin
                    ehit  = 1'b1;
                    edata = cur.data;
                end
                foreach (exp_q[k]) begin
                    if (exp_q[k].sel == fwd_sel) begin
                        ehit  = 1'b1;
                        edata = exp_q[k].data;
                    end
                end
            end
            check("fwd_hit",  32'(FWD_HIT),  32'(ehit));
            check("fwd_data", 32'(FWD_DATA), 32'(edata));
`else
            ehit  = 1'b0;
            edata = '0;
`endif
        end
    end

    initial begin
        #3;
        check("init_dsel",   32'(DSEL),      32'd0);
        check("init_rin",    32'(RIN),       32'd0);
        check("init_busy",   32'(BUSY),      32'd0);
        check("init_qlevel", 32'(QLEVEL),    32'd0);
        check("init_ready",  32'(RES_READY), 32'd0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;

        // single write to R3, then idle
        step(1'b1, 3'd3, 16'hA5A5);
        step(1'b0, 3'd0, 16'h0000);
        step(1'b0, 3'd0, 16'h0000);
        step(1'b0, 3'd0, 16'h0000);

        // back-to-back R1..R6 with valid held high
        for (int i = 1; i <= 6; i++) step(1'b1, AW'(i), DW'(i));
        step(1'b0, 3'd0, 16'h0000);
        step(1'b0, 3'd0, 16'h0000);

        // same register twice
        step(1'b1, 3'd5, 16'h1111);
        step(1'b1, 3'd5, 16'h2222);
        step(1'b0, 3'd0, 16'h0000);
        step(1'b0, 3'd0, 16'h0000);

        // discard write still completes the handshake
        step(1'b1, 3'd0, 16'hFFFF);
        check("discard_ready", 32'(RES_READY), 32'd1);
        step(1'b0, 3'd0, 16'h0000);
        step(1'b0, 3'd0, 16'h0000);

        // forwarding probe on R2 then R4
        step(1'b1, 3'd2, 16'h0010);
        step(1'b1, 3'd2, 16'h0020);
`ifdef REGFILE_WB_FWD_EN
        fwd_sel = 3'd2;
`endif
        step(1'b0, 3'd0, 16'h0000);
`ifdef REGFILE_WB_FWD_EN
        fwd_sel = 3'd4;
`endif
        step(1'b0, 3'd0, 16'h0000);

        // reset in the middle of a stream
        step(1'b1, 3'd4, 16'h1234);
        step(1'b1, 3'd6, 16'h5678);
        do_reset();
        step(1'b0, 3'd0, 16'h0000);
        step(1'b0, 3'd0, 16'h0000);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), DW'($urandom));
            if (n == 200) do_reset();
        end
        for (int n = 0; n < 4; n++) step(1'b0, 3'd0, 16'h0000);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected completion before %0t", $time);
        $fatal(1);
    end

endmodule
